// File: rtl/approx_lut_pkg.sv
// rtl/approx_lut_pkg.sv - shared constants, config FSM encoding and table-depth helper
package approx_lut_pkg;

    // 1RS truth table: O = I4 | (I3 & I2 & I1 & I0), bit i is the output for index i
    localparam logic [31:0] LUT_INIT_1RS = 32'hFFFF_8000;

    typedef enum logic [1:0] {
        CFG_IDLE   = 2'd0,
        CFG_LOAD   = 2'd1,
        CFG_COMMIT = 2'd2
    } cfg_state_e;

    function automatic int tbl_depth(input int k);
        return 1 << k;
    endfunction

endpackage

// File: rtl/approx_lut_cfg_fsm.sv
// rtl/approx_lut_cfg_fsm.sv - serial reload FSM: bit counter, shadow table and cfg handshake
module approx_lut_cfg_fsm
    import approx_lut_pkg::*;
#(
    parameter int K  = 5,
    parameter int CW = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_start_i,
    input  logic [CW-1:0]             cfg_ch_i,
    input  logic                      cfg_valid_i,
    input  logic                      cfg_bit_i,
    input  logic                      cfg_abort_i,
    output logic                      cfg_ready_o,
    output logic                      cfg_busy_o,
    output logic                      cfg_done_o,
    output logic                      commit_o,
    output logic [CW-1:0]             commit_ch_o,
    output logic [tbl_depth(K)-1:0]   shadow_o
);
    localparam int TBL = tbl_depth(K);

    cfg_state_e         state_q, state_d;
    logic [K-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]      ch_q, ch_d;
    logic [TBL-1:0]     shadow_q, shadow_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CFG_IDLE;
            cnt_q    <= '0;
            ch_q     <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ch_q     <= ch_d;
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ch_d     = ch_q;
        shadow_d = shadow_q;
        unique case (state_q)
            CFG_IDLE: begin
                if (cfg_start_i) begin
                    state_d = CFG_LOAD;
                    ch_d    = cfg_ch_i;
                    cnt_d   = '0;
                end
            end
            CFG_LOAD: begin
                // abort takes priority over a beat presented in the same cycle
                if (cfg_abort_i) begin
                    state_d  = CFG_IDLE;
                    cnt_d    = '0;
                    shadow_d = '0;
                end else if (cfg_valid_i) begin
                    shadow_d[cnt_q] = cfg_bit_i;
                    cnt_d           = cnt_q + K'(1);
                    if (&cnt_q) state_d = CFG_COMMIT;
                end
            end
            CFG_COMMIT: state_d = CFG_IDLE;
            default:    state_d = CFG_IDLE;
        endcase
    end

    assign cfg_ready_o = (state_q == CFG_LOAD);
    assign cfg_busy_o  = (state_q != CFG_IDLE);
    assign cfg_done_o  = (state_q == CFG_COMMIT);
    assign commit_o    = (state_q == CFG_COMMIT);
    assign commit_ch_o = ch_q;
    assign shadow_o    = shadow_q;

endmodule

// File: rtl/approx_lut_bank.sv
// rtl/approx_lut_bank.sv - bank of reprogrammable K-input LUTs with one-cycle registered evaluation
module approx_lut_bank
    import approx_lut_pkg::*;
#(
    parameter int                        K            = 5,
    parameter int                        N_CH         = 4,
    parameter logic [tbl_depth(K)-1:0]   INIT_DEFAULT = LUT_INIT_1RS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [N_CH*K-1:0]         in_data,
    input  logic [N_CH-1:0]           ch_en,
    output logic                      out_valid,
    output logic [N_CH-1:0]           out_data,
    input  logic                      cfg_start,
    input  logic [$clog2(N_CH)-1:0]   cfg_ch,
    input  logic                      cfg_valid,
    input  logic                      cfg_bit,
    output logic                      cfg_ready,
    input  logic                      cfg_abort,
    output logic                      cfg_busy,
    output logic                      cfg_done
);
    localparam int TBL = tbl_depth(K);
    localparam int CW  = $clog2(N_CH);

    logic [TBL-1:0]   tbl_q [N_CH];
    logic             out_valid_q;
    logic [N_CH-1:0]  out_data_q;
    logic             commit;
    logic [CW-1:0]    commit_ch;
    logic [TBL-1:0]   shadow;

    approx_lut_cfg_fsm #(.K(K), .CW(CW)) u_cfg_fsm (
        .clk         (clk),
        .rst         (rst),
        .cfg_start_i (cfg_start),
        .cfg_ch_i    (cfg_ch),
        .cfg_valid_i (cfg_valid),
        .cfg_bit_i   (cfg_bit),
        .cfg_abort_i (cfg_abort),
        .cfg_ready_o (cfg_ready),
        .cfg_busy_o  (cfg_busy),
        .cfg_done_o  (cfg_done),
        .commit_o    (commit),
        .commit_ch_o (commit_ch),
        .shadow_o    (shadow)
    );

    // eval and commit share an edge, so an eval in the COMMIT cycle sees the old table
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int c = 0; c < N_CH; c++) tbl_q[c] <= INIT_DEFAULT;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                for (int c = 0; c < N_CH; c++)
                    out_data_q[c] <= ch_en[c] & tbl_q[c][in_data[c*K +: K]];
            end
            if (commit) begin
                for (int c = 0; c < N_CH; c++)
                    if (commit_ch == CW'(c)) tbl_q[c] <= shadow;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_approx_lut_bank.sv
// tb/tb_approx_lut_bank.sv - directed self-checking bench for approx_lut_bank
module tb_approx_lut_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [19:0] in_data;
    logic [3:0]  ch_en;
    logic        out_valid;
    logic [3:0]  out_data;
    logic        cfg_start;
    logic [1:0]  cfg_ch;
    logic        cfg_valid;
    logic        cfg_bit;
    logic        cfg_ready;
    logic        cfg_abort;
    logic        cfg_busy;
    logic        cfg_done;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;

    approx_lut_bank dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .ch_en     (ch_en),
        .out_valid (out_valid),
        .out_data  (out_data),
        .cfg_start (cfg_start),
        .cfg_ch    (cfg_ch),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .cfg_abort (cfg_abort),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cfg_done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ev(input logic [4:0] i0, input logic [4:0] i1, input logic [4:0] i2,
                      input logic [4:0] i3, input logic [3:0] en);
        in_data  = {i3, i2, i1, i0};
        ch_en    = en;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // leaves the FSM in COMMIT (observed) after the 32nd beat
    task automatic load_tbl(input logic [1:0] ch, input logic [31:0] data);
        cfg_ch    = ch;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            cfg_valid = 1'b1;
            cfg_bit   = data[i];
            tick();
        end
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
    endtask

    initial begin
        int d0;
        int acc;
        int cyc;
        logic [31:0] pat;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; ch_en = 4'hF;
        cfg_start = 1'b0; cfg_ch = '0; cfg_valid = 1'b0; cfg_bit = 1'b0; cfg_abort = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", {28'b0, out_data}, 32'd0);
        chk("rst_busy_ready_done", {29'b0, cfg_busy, cfg_ready, cfg_done}, 32'd0);

        // default 1RS function
        ev(5'b01111, 5'd0, 5'd0, 5'd0, 4'hF);
        chk("t1_valid", {31'b0, out_valid}, 32'd1);
        chk("t1_idx15", {28'b0, out_data}, 32'h1);
        ev(5'b01110, 5'd0, 5'd0, 5'd0, 4'hF);
        chk("t1_idx14", {28'b0, out_data}, 32'h0);
        ev(5'b10000, 5'd0, 5'd0, 5'd0, 4'hF);
        chk("t1_idx16", {28'b0, out_data}, 32'h1);
        tick();
        chk("t1_hold_valid", {31'b0, out_valid}, 32'd0);
        chk("t1_hold_data", {28'b0, out_data}, 32'h1);
        ev(5'b10000, 5'b10000, 5'b10000, 5'b10000, 4'b1010);
        chk("t1_ch_en", {28'b0, out_data}, 32'hA);

        // load ch1 with 32'h1
        d0 = done_cnt;
        load_tbl(2'd1, 32'h0000_0001);
        chk("t2_done", {31'b0, cfg_done}, 32'd1);
        chk("t2_busy_ready", {30'b0, cfg_busy, cfg_ready}, 32'b10);
        tick(); tick();
        chk("t2_done_pulses", done_cnt - d0, 32'd1);
        chk("t2_idle", {31'b0, cfg_busy}, 32'd0);
        ev(5'b10000, 5'b00000, 5'b10000, 5'b01111, 4'hF);
        chk("t2_ch1_idx0", {28'b0, out_data}, 32'hF);
        ev(5'b10000, 5'b10000, 5'b10000, 5'b01111, 4'hF);
        chk("t2_ch1_idx16", {28'b0, out_data}, 32'hD);

        // eval during COMMIT sees old table
        load_tbl(2'd1, 32'h0000_0000);
        chk("t4_in_commit", {31'b0, cfg_done}, 32'd1);
        ev(5'd0, 5'b00000, 5'd0, 5'd0, 4'hF);
        chk("t4_old", {28'b0, out_data}, 32'h2);
        ev(5'd0, 5'b00000, 5'd0, 5'd0, 4'hF);
        chk("t4_new", {28'b0, out_data}, 32'h0);

        // abort ch2 after 10 beats, abort wins over a concurrent beat
        d0 = done_cnt;
        cfg_ch = 2'd2; cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cfg_valid = 1'b1; cfg_bit = 1'b0; tick();
        end
        cfg_abort = 1'b1; tick();
        cfg_abort = 1'b0; cfg_valid = 1'b0;
        chk("t3_abort_idle", {30'b0, cfg_busy, cfg_ready}, 32'b00);
        tick();
        ev(5'd0, 5'd0, 5'b10000, 5'd0, 4'hF);
        chk("t3_ch2_default", {28'b0, out_data}, 32'h4);
        chk("t3_no_done", done_cnt - d0, 32'd0);
        cfg_ch = 2'd2; cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        chk("t3_restart", {30'b0, cfg_busy, cfg_ready}, 32'b11);
        cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;
        cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;
        chk("t3_abort_outside_load", {31'b0, cfg_busy}, 32'd0);

        // reset mid-load restores defaults
        load_tbl(2'd3, 32'h0000_0000);
        tick();
        ev(5'd0, 5'd0, 5'd0, 5'b10000, 4'hF);
        chk("t5_ch3_loaded", {28'b0, out_data}, 32'h0);
        d0 = done_cnt;
        cfg_ch = 2'd0; cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cfg_valid = 1'b1; cfg_bit = 1'b0; tick();
        end
        in_valid = 1'b1; rst = 1'b1; tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("t5_rst_busy", {31'b0, cfg_busy}, 32'd0);
        chk("t5_rst_out_valid", {31'b0, out_valid}, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        chk("t5_no_done", done_cnt - d0, 32'd0);
        cfg_valid = 1'b0;
        ev(5'b10000, 5'b10000, 5'd0, 5'b10000, 4'hF);
        chk("t5_defaults", {28'b0, out_data}, 32'hB);

        // cfg_start during LOAD ignored, gapped beats
        d0 = done_cnt;
        pat = 32'h8000_0001;
        cfg_ch = 2'd0; cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        acc = 0; cyc = 0;
        while (acc < 32 && cyc < 200) begin
            cfg_valid = (cyc % 3 != 2);
            cfg_bit   = pat[acc];
            cfg_start = (cyc == 7);
            cfg_ch    = (cyc == 7) ? 2'd2 : 2'd0;
            tick();
            if (cfg_valid) acc++;
            cyc++;
            if (acc == 31 && cfg_valid) chk("t6_still_loading", {30'b0, cfg_ready, cfg_done}, 32'b10);
        end
        cfg_valid = 1'b0; cfg_start = 1'b0;
        chk("t6_done_after_32", {31'b0, cfg_done}, 32'd1);
        tick();
        chk("t6_one_pulse", done_cnt - d0, 32'd1);
        ev(5'b10000, 5'b10000, 5'b10000, 5'b10000, 4'hF);
        chk("t6_idx16", {28'b0, out_data}, 32'hE);
        ev(5'b11111, 5'd0, 5'd0, 5'd0, 4'hF);
        chk("t6_idx31_idx0", {28'b0, out_data}, 32'h1);
        ev(5'b00000, 5'b00000, 5'b00000, 5'b00000, 4'hF);
        chk("t6_ch0_idx0", {28'b0, out_data}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
